// File: rtl/if_fetch_unit_if.sv
// Fetch-stage handshake bundle: redirect input, instruction-memory port and decode buffer port.
// master = fetch unit, slave = surrounding pipeline/memory.
interface if_fetch_unit_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/if_fetch_unit.sv
// RV64 instruction fetch: one outstanding 8-byte read, 32-bit word select, one-entry decode buffer.
// Optional perf counters (fetch/drop/stall) when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  if_fetch_unit_if.master fif
`ifdef IF_PERF_CNT_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_drop_cnt,
  output logic [63:0] perf_stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  state;
  logic [63:0] pc;
  logic [63:0] req_pc;
  logic        drop;
  logic        inst_vld_q;
  logic [31:0] inst_q;
  logic [63:0] inst_pc_q;

  logic        redir;
  logic [63:0] redir_pc;
  logic [63:0] pc_eff;
  logic        req_word;
  logic        resp;
  logic        load;
  logic        buf_free;
  logic [31:0] word;
  logic        unused_redir_lsb;

  assign redir            = fif.redirect_valid;
  assign redir_pc         = {fif.redirect_pc[63:2], 2'b00};
  assign unused_redir_lsb = ^fif.redirect_pc[1:0];
  // A redirect seen while leaving IDLE is captured directly so the request targets the new PC.
  assign pc_eff   = redir ? redir_pc : pc;
  assign req_word = req_pc[2];
  assign resp     = (state == S_WAIT) && fif.imem_resp_valid;
  assign load     = resp && !drop && !redir;
  assign buf_free = !inst_vld_q || fif.inst_ready || redir;
  assign word     = req_word ? fif.imem_resp_data[63:32] : fif.imem_resp_data[31:0];

  assign fif.imem_req_valid = (state == S_REQ);
  assign fif.imem_req_addr  = {req_pc[63:3], 3'b000};
  assign fif.inst_valid     = inst_vld_q;
  assign fif.inst           = inst_q;
  assign fif.inst_pc        = inst_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= PC_RESET;
      req_pc     <= PC_RESET;
      drop       <= 1'b0;
      inst_vld_q <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (buf_free) begin
          state  <= S_REQ;
          req_pc <= pc_eff;
        end
        S_REQ:  if (fif.imem_req_ready) state <= S_WAIT;
        S_WAIT: if (fif.imem_resp_valid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // The pending request is never withdrawn; its response is marked stale instead.
      if (resp)
        drop <= 1'b0;
      else if (redir && (state == S_REQ || state == S_WAIT))
        drop <= 1'b1;

      if (redir)
        pc <= redir_pc;
      else if (load)
        pc <= req_pc + 64'd4;

      if (load) begin
        inst_q    <= word;
        inst_pc_q <= req_pc;
      end

      if (redir)
        inst_vld_q <= 1'b0;
      else if (load)
        inst_vld_q <= 1'b1;
      else if (fif.inst_ready)
        inst_vld_q <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (load)
        perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (resp && (drop || redir))
        perf_drop_cnt <= perf_drop_cnt + 64'd1;
      if (inst_vld_q && !fif.inst_ready)
        perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule
